multi_purchase_manager: RTL
===========================

MULTI_PURCHASE_MANAGER -- requirements
Module: multi_purchase_manager

Interface
REQ-001 Parameter NUM_PRODUCTS, default 4: number of product channels, 2..16.
REQ-002 Parameter CREDIT_W, default 8: width of credit, price and change values.
REQ-003 Parameter STOCK_W, default 4: width of each per-product stock counter.
REQ-004 Parameter INIT_STOCK, default 3: stock loaded into every counter on reset and on restock; SHALL fit STOCK_W.
REQ-005 Parameter PRICES, default {8'd40, 8'd30, 8'd20, 8'd75}: packed NUM_PRODUCTS x CREDIT_W price table; product i at bits [i*CREDIT_W +: CREDIT_W] (0=apple 75, 1=banana 20, 2=carrot 30, 3=date 40).
REQ-006 SEL_W is derived as max(1, clog2(NUM_PRODUCTS)).
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 reset  input  1  asynchronous active-low reset.
REQ-010 buy  input  1  purchase request, level; a rising edge starts a transaction.
REQ-011 product  input  SEL_W  selected product index.
REQ-012 credit  input  CREDIT_W  credit offered, unsigned.
REQ-013 restock  input  1  reload all stock counters.
REQ-014 dispense  output  NUM_PRODUCTS  one-hot, one-cycle pulse on the sold product.
REQ-015 change  output  CREDIT_W  credit minus price of the last successful sale.
REQ-016 error  output  1  one-cycle pulse on a rejected transaction.
REQ-017 err_code  output  2  rejection reason: 01 insufficient credit, 10 sold out, 11 invalid product, 00 none.
REQ-018 sold_out  output  NUM_PRODUCTS  bit i high while stock[i]==0.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 buy SHALL be registered once; start = buy & ~buy_q, evaluated only in IDLE. Edges seen in other states SHALL be dropped, not queued.
REQ-021 FSM states: IDLE, CHECK, DISPENSE, REJECT. IDLE->CHECK on start; CHECK->DISPENSE or REJECT; DISPENSE->IDLE; REJECT->IDLE, each after one cycle.
REQ-022 On start, product and credit SHALL be captured; later input changes SHALL not affect the transaction.
REQ-023 CHECK priority: (1) product >= NUM_PRODUCTS -> REJECT, code 11; (2) stock==0 -> REJECT, code 10; (3) credit < price -> REJECT, code 01; otherwise DISPENSE.
REQ-024 credit == price SHALL be accepted with change 0.
REQ-025 Latency: for a buy edge sampled at clock edge N, the dispense or error pulse SHALL be visible after edge N+2 and last exactly one cycle.
REQ-026 In DISPENSE: dispense[product] = 1; change = captured credit - price (CREDIT_W-bit, never negative); stock[product] decrements by 1.
REQ-027 change SHALL hold its value until the next successful sale; a REJECT SHALL leave change unchanged.
REQ-028 err_code SHALL hold until the next transaction result and SHALL be cleared to 00 on a successful sale.
REQ-029 restock SHALL set every counter to INIT_STOCK in any state; if it coincides with a decrement, restock wins.
REQ-030 Stock counters SHALL never underflow or exceed INIT_STOCK.
REQ-031 Throughput: at most one transaction per 3 cycles; buy must be low for at least one sampled cycle to re-arm.

Reset
REQ-032 While reset is low: state=IDLE, buy_q=0, dispense=0, change=0, error=0, err_code=00, busy=0, all stock=INIT_STOCK, sold_out=0.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately with no dispense pulse and no stock change; operation resumes on the first edge after release.

Verification
REQ-034 product=0, credit=75, buy rises -> dispense=0001 two edges later for one cycle; change=0; stock[0] 3->2.
REQ-035 product=3, credit=50, buy rises -> dispense=1000; change=10; buy held high 5 cycles -> no second sale.
REQ-036 product=2, credit=0, buy rises -> error pulse, err_code=01; change keeps its previous value; stock unchanged.
REQ-037 Four sales of product 1 at credit=20 -> first three dispense; fourth -> error, err_code=10, sold_out[1]=1; restock -> sold_out=0000, next sale succeeds.
REQ-038 NUM_PRODUCTS=3, product=3 -> error with err_code=11. Separately: reset low during CHECK -> no dispense, all outputs 0, stock=INIT_STOCK.

Source files
------------

// File: rtl/multi_purchase_manager.sv
// Multi-product vending purchase manager.
// A rising edge on buy (sampled in IDLE) captures product/credit, checks
// validity, stock and credit, then either dispenses (one-hot pulse, change
// update, stock decrement) or rejects (error pulse with a reason code).
// Ports:
//   clk, reset      : clock and asynchronous active-low reset
//   buy             : purchase request level; rising edge starts a transaction
//   product, credit : selected product index and offered credit
//   restock         : reload every stock counter to INIT_STOCK
//   dispense        : one-cycle one-hot pulse on the sold product
//   change          : credit minus price of the last successful sale
//   error, err_code : one-cycle reject pulse and held rejection reason
//   sold_out        : per-product stock-empty flags
//   busy            : high whenever a transaction is in flight
module multi_purchase_manager #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned INIT_STOCK   = 3,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd75},
    localparam int unsigned SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    buy,
    input  logic [SEL_W-1:0]        product,
    input  logic [CREDIT_W-1:0]     credit,
    input  logic                    restock,
    output logic [NUM_PRODUCTS-1:0] dispense,
    output logic [CREDIT_W-1:0]     change,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic                    busy
);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_CREDIT  = 2'b01;
    localparam logic [1:0] CODE_SOLDOUT = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        DISPENSE = 2'd2,
        REJECT   = 2'd3
    } state_t;

    state_t                    state, state_d;
    logic                      buy_q;
    logic [SEL_W-1:0]          prod_q, prod_d;
    logic [CREDIT_W-1:0]       cred_q, cred_d;
    logic [1:0]                pend_q, pend_d;
    logic [STOCK_W-1:0]        stock   [NUM_PRODUCTS];
    logic [STOCK_W-1:0]        stock_d [NUM_PRODUCTS];
    logic [NUM_PRODUCTS-1:0]   dispense_d;
    logic [CREDIT_W-1:0]       change_d;
    logic                      error_d;
    logic [1:0]                err_code_d;
    logic [NUM_PRODUCTS-1:0]   sold_out_d;
    logic                      busy_d;

    logic                      sel_valid;
    logic [CREDIT_W-1:0]       sel_price;
    logic [STOCK_W-1:0]        sel_stock;
    logic                      start;

    // Lookup of the captured product; a loop keeps out-of-range indices harmless.
    always_comb begin
        sel_valid = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            if (prod_q == SEL_W'(i)) begin
                sel_valid = 1'b1;
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock[i];
            end
        end
    end

    assign start = buy & ~buy_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        prod_d     = prod_q;
        cred_d     = cred_q;
        pend_d     = pend_q;
        dispense_d = '0;
        change_d   = change;
        error_d    = 1'b0;
        err_code_d = err_code;
        for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            stock_d[i] = stock[i];
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    prod_d  = product;
                    cred_d  = credit;
                end
            end
            CHECK: begin
                state_d = REJECT;
                if (!sel_valid) begin
                    pend_d = CODE_INVALID;
                end else if (sel_stock == '0) begin
                    pend_d = CODE_SOLDOUT;
                end else if (cred_q < sel_price) begin
                    pend_d = CODE_CREDIT;
                end else begin
                    state_d = DISPENSE;
                end
            end
            DISPENSE: begin
                state_d    = IDLE;
                change_d   = cred_q - sel_price;
                err_code_d = CODE_NONE;
                for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                    if (prod_q == SEL_W'(i)) begin
                        dispense_d[i] = 1'b1;
                        if (stock[i] != '0) begin
                            stock_d[i] = stock[i] - STOCK_W'(1);
                        end
                    end
                end
            end
            REJECT: begin
                state_d    = IDLE;
                error_d    = 1'b1;
                err_code_d = pend_q;
            end
            default: state_d = IDLE;
        endcase

        // Restock overrides any concurrent decrement.
        if (restock) begin
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                stock_d[i] = STOCK_W'(INIT_STOCK);
            end
        end

        for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            buy_q    <= 1'b0;
            prod_q   <= '0;
            cred_q   <= '0;
            pend_q   <= CODE_NONE;
            dispense <= '0;
            change   <= '0;
            error    <= 1'b0;
            err_code <= CODE_NONE;
            sold_out <= '0;
            busy     <= 1'b0;
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state    <= state_d;
            buy_q    <= buy;
            prod_q   <= prod_d;
            cred_q   <= cred_d;
            pend_q   <= pend_d;
            dispense <= dispense_d;
            change   <= change_d;
            error    <= error_d;
            err_code <= err_code_d;
            sold_out <= sold_out_d;
            busy     <= busy_d;
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                stock[i] <= stock_d[i];
            end
        end
    end

endmodule
